// File: rtl/rv_ctrl_pkg.sv
// Shared RV32I control encodings: opcodes, ALU operation classes, operand/PC/extend selects.
// Used by the control unit, decode_unit and execution_unit.
package rv_ctrl_pkg;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    ALU_RTYPE  = 3'b000,
    ALU_ITYPE  = 3'b001,
    ALU_BRANCH = 3'b010,
    ALU_JUMP   = 3'b011,
    ALU_LOAD   = 3'b100,
    ALU_STORE  = 3'b101,
    ALU_LUI    = 3'b110,
    ALU_AUIPC  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    NPC_PLUS4  = 2'b00,
    NPC_BRANCH = 2'b01,
    NPC_JAL    = 2'b10,
    NPC_JALR   = 2'b11
  } next_pc_e;

  typedef enum logic [1:0] {
    OPA_RS1      = 2'b00,
    OPA_PC       = 2'b01,
    OPA_PC_PLUS4 = 2'b10,
    OPA_ZERO     = 2'b11
  } opa_sel_e;

  typedef enum logic [1:0] {
    EXT_I = 2'b00,
    EXT_U = 2'b01,
    EXT_S = 2'b10
  } ext_sel_e;

  typedef struct packed {
    logic     branch_op;
    logic     mem_read;
    alu_op_e  alu_op;
    logic     mem_write;
    next_pc_e next_pc_sel;
    opa_sel_e opa_sel;
    logic     opb_sel;
    ext_sel_e ext_sel;
    logic     reg_write;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // Instruction classes tracked by the optional performance counters.
  typedef enum logic [2:0] {
    CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JUMP, CLS_UPPER, CLS_NOP
  } op_class_e;

  function automatic op_class_e classify(input logic [6:0] opc);
    case (opc)
      OPC_RTYPE:          return CLS_R;
      OPC_ITYPE:          return CLS_I;
      OPC_LOAD:           return CLS_LOAD;
      OPC_STORE:          return CLS_STORE;
      OPC_BRANCH:         return CLS_BRANCH;
      OPC_JAL, OPC_JALR:  return CLS_JUMP;
      OPC_LUI, OPC_AUIPC: return CLS_UPPER;
      default:            return CLS_NOP;
    endcase
  endfunction

endpackage

// File: rtl/riscv_control_perf_counters.sv
// Per-class instruction counters for the control unit; printed on a report request.
// Only instantiated when CU_PERF_COUNTERS_EN is defined.
module riscv_control_perf_counters
  import rv_ctrl_pkg::*;
#(
  parameter int CORE = 0
) (
  input logic       clock,
  input logic       reset,
  input logic [6:0] opcode,
  input logic       report
);

  logic [31:0] cycles;
  logic [31:0] r_cnt;
  logic [31:0] i_cnt;
  logic [31:0] load_cnt;
  logic [31:0] store_cnt;
  logic [31:0] branch_cnt;
  logic [31:0] jump_cnt;
  logic [31:0] upper_cnt;
  logic [31:0] nop_cnt;

  // Exactly one class counter advances per cycle; all wrap naturally at 2^32.
  always_ff @(posedge clock) begin
    if (reset) begin
      cycles     <= '0;
      r_cnt      <= '0;
      i_cnt      <= '0;
      load_cnt   <= '0;
      store_cnt  <= '0;
      branch_cnt <= '0;
      jump_cnt   <= '0;
      upper_cnt  <= '0;
      nop_cnt    <= '0;
    end else begin
      cycles <= cycles + 32'd1;
      case (classify(opcode))
        CLS_R:      r_cnt      <= r_cnt + 32'd1;
        CLS_I:      i_cnt      <= i_cnt + 32'd1;
        CLS_LOAD:   load_cnt   <= load_cnt + 32'd1;
        CLS_STORE:  store_cnt  <= store_cnt + 32'd1;
        CLS_BRANCH: branch_cnt <= branch_cnt + 32'd1;
        CLS_JUMP:   jump_cnt   <= jump_cnt + 32'd1;
        CLS_UPPER:  upper_cnt  <= upper_cnt + 32'd1;
        default:    nop_cnt    <= nop_cnt + 32'd1;
      endcase
    end
  end

`ifndef SYNTHESIS
  // Values read here are the ones held before this edge's increment.
  always @(posedge clock) begin
    if (report && !reset)
      $display("[CU core %0d] cycles=%0d r=%0d i=%0d load=%0d store=%0d branch=%0d jump=%0d upper=%0d nop=%0d",
               CORE, cycles, r_cnt, i_cnt, load_cnt, store_cnt, branch_cnt, jump_cnt,
               upper_cnt, nop_cnt);
  end
`endif

endmodule

// File: rtl/riscv_control_unit.sv
// Main RV32I pipeline decoder: purely combinational control from the ID/EX opcode.
// Optional class counters are enabled with the CU_PERF_COUNTERS_EN macro.
module riscv_control_unit
  import rv_ctrl_pkg::*;
#(
  parameter int CORE = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       report,
  output logic       branch_op,
  output logic       memRead,
  output logic [2:0] ALUOp,
  output logic       memWrite,
  output logic [1:0] next_PC_sel,
  output logic [1:0] operand_A_sel,
  output logic       operand_B_sel,
  output logic [1:0] extend_sel,
  output logic       regWrite
);

  ctrl_t ctrl;

  // Undefined opcodes (bubbles, SYSTEM, FENCE) fall through as a NOP with no writes.
  always_comb begin
    ctrl = CTRL_NOP;
    if (!reset) begin
      case (opcode)
        OPC_RTYPE: begin
          ctrl.alu_op    = ALU_RTYPE;
          ctrl.reg_write = 1'b1;
        end
        OPC_ITYPE: begin
          ctrl.alu_op    = ALU_ITYPE;
          ctrl.opb_sel   = 1'b1;
          ctrl.ext_sel   = EXT_I;
          ctrl.reg_write = 1'b1;
        end
        OPC_LOAD: begin
          ctrl.alu_op    = ALU_LOAD;
          ctrl.mem_read  = 1'b1;
          ctrl.opb_sel   = 1'b1;
          ctrl.ext_sel   = EXT_I;
          ctrl.reg_write = 1'b1;
        end
        OPC_STORE: begin
          ctrl.alu_op    = ALU_STORE;
          ctrl.mem_write = 1'b1;
          ctrl.opb_sel   = 1'b1;
          ctrl.ext_sel   = EXT_S;
        end
        OPC_BRANCH: begin
          ctrl.alu_op      = ALU_BRANCH;
          ctrl.branch_op   = 1'b1;
          ctrl.next_pc_sel = NPC_BRANCH;
        end
        OPC_JAL: begin
          ctrl.alu_op      = ALU_JUMP;
          ctrl.next_pc_sel = NPC_JAL;
          ctrl.opa_sel     = OPA_PC_PLUS4;
          ctrl.reg_write   = 1'b1;
        end
        OPC_JALR: begin
          ctrl.alu_op      = ALU_JUMP;
          ctrl.next_pc_sel = NPC_JALR;
          ctrl.opa_sel     = OPA_PC_PLUS4;
          ctrl.opb_sel     = 1'b1;
          ctrl.ext_sel     = EXT_I;
          ctrl.reg_write   = 1'b1;
        end
        OPC_LUI: begin
          ctrl.alu_op    = ALU_LUI;
          ctrl.opa_sel   = OPA_ZERO;
          ctrl.opb_sel   = 1'b1;
          ctrl.ext_sel   = EXT_U;
          ctrl.reg_write = 1'b1;
        end
        OPC_AUIPC: begin
          ctrl.alu_op    = ALU_AUIPC;
          ctrl.opa_sel   = OPA_PC;
          ctrl.opb_sel   = 1'b1;
          ctrl.ext_sel   = EXT_U;
          ctrl.reg_write = 1'b1;
        end
        default: ctrl = CTRL_NOP;
      endcase
    end
  end

  assign branch_op     = ctrl.branch_op;
  assign memRead       = ctrl.mem_read;
  assign ALUOp         = ctrl.alu_op;
  assign memWrite      = ctrl.mem_write;
  assign next_PC_sel   = ctrl.next_pc_sel;
  assign operand_A_sel = ctrl.opa_sel;
  assign operand_B_sel = ctrl.opb_sel;
  assign extend_sel    = ctrl.ext_sel;
  assign regWrite      = ctrl.reg_write;

`ifdef CU_PERF_COUNTERS_EN
  riscv_control_perf_counters #(
    .CORE(CORE)
  ) u_perf (
    .clock (clock),
    .reset (reset),
    .opcode(opcode),
    .report(report)
  );
`else
  // Without counters the clock, report request and core index have no consumer.
  localparam int unused_core_idx = CORE;
  logic unused_perf_inputs;
  assign unused_perf_inputs = ^{clock, report};
`endif

endmodule

// File: tb/tb_riscv_control_unit.sv
// Self-checking bench for riscv_control_unit: table-driven decode reference plus counter model.
// Counter scenarios run only when CU_PERF_COUNTERS_EN is defined.
module tb_riscv_control_unit;

  logic       clock;
  logic       reset;
  logic [6:0] opcode;
  logic       report;
  logic       branch_op;
  logic       memRead;
  logic [2:0] ALUOp;
  logic       memWrite;
  logic [1:0] next_PC_sel;
  logic [1:0] operand_A_sel;
  logic       operand_B_sel;
  logic [1:0] extend_sel;
  logic       regWrite;

  int vectors;
  int miscompares;

  // Expected control word per defined opcode, written straight from the opcode table.
  logic [13:0] golden [logic [6:0]];
  logic [6:0]  defined_ops [9];

  riscv_control_unit #(.CORE(0)) dut (
    .clock        (clock),
    .reset        (reset),
    .opcode       (opcode),
    .report       (report),
    .branch_op    (branch_op),
    .memRead      (memRead),
    .ALUOp        (ALUOp),
    .memWrite     (memWrite),
    .next_PC_sel  (next_PC_sel),
    .operand_A_sel(operand_A_sel),
    .operand_B_sel(operand_B_sel),
    .extend_sel   (extend_sel),
    .regWrite     (regWrite)
  );

  always #5 clock = ~clock;

  function automatic logic [13:0] vec(input logic br, input logic mr, input logic [2:0] alu,
                                      input logic mw, input logic [1:0] npc, input logic [1:0] opa,
                                      input logic opb, input logic [1:0] ext, input logic rw);
    return {br, mr, alu, mw, npc, opa, opb, ext, rw};
  endfunction

  function automatic logic [13:0] actual_vec();
    return {branch_op, memRead, ALUOp, memWrite, next_PC_sel, operand_A_sel,
            operand_B_sel, extend_sel, regWrite};
  endfunction

  function automatic logic [13:0] model(input logic [6:0] opc, input logic rst);
    if (rst) return '0;
    if (golden.exists(opc)) return golden[opc];
    return '0;
  endfunction

  task automatic build_table();
    golden[7'b0110011] = vec(0, 0, 3'b000, 0, 2'b00, 2'b00, 0, 2'b00, 1);
    golden[7'b0010011] = vec(0, 0, 3'b001, 0, 2'b00, 2'b00, 1, 2'b00, 1);
    golden[7'b0000011] = vec(0, 1, 3'b100, 0, 2'b00, 2'b00, 1, 2'b00, 1);
    golden[7'b0100011] = vec(0, 0, 3'b101, 1, 2'b00, 2'b00, 1, 2'b10, 0);
    golden[7'b1100011] = vec(1, 0, 3'b010, 0, 2'b01, 2'b00, 0, 2'b00, 0);
    golden[7'b1101111] = vec(0, 0, 3'b011, 0, 2'b10, 2'b10, 0, 2'b00, 1);
    golden[7'b1100111] = vec(0, 0, 3'b011, 0, 2'b11, 2'b10, 1, 2'b00, 1);
    golden[7'b0110111] = vec(0, 0, 3'b110, 0, 2'b00, 2'b11, 1, 2'b01, 1);
    golden[7'b0010111] = vec(0, 0, 3'b111, 0, 2'b00, 2'b01, 1, 2'b01, 1);
    defined_ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                    7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
  endtask

  task automatic applyStimulus(input logic [6:0] opc, input logic rst);
    opcode = opc;
    reset  = rst;
    #1;
  endtask

  task automatic test_reset();
    logic [13:0] got;
    applyStimulus(7'b0110011, 1'b1);
    got = actual_vec();
    vectors++;
    if (got !== 14'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs got=%b want=%b", got, 14'd0);
    end
  endtask

  task automatic test_defined_opcodes();
    logic [13:0] got;
    for (int k = 0; k < 9; k++) begin
      applyStimulus(defined_ops[k], 1'b0);
      got = actual_vec();
      vectors++;
      if (got !== model(defined_ops[k], 1'b0)) begin
        miscompares++;
        $display("[TB] FAIL decode_%b got=%b want=%b", defined_ops[k], got,
                 model(defined_ops[k], 1'b0));
      end
    end
  endtask

  task automatic test_undefined_opcodes();
    logic [6:0]  ops [4];
    logic [13:0] got;
    ops = '{7'b0000000, 7'b1110011, 7'b0001111, 7'b1111111};
    for (int k = 0; k < 4; k++) begin
      applyStimulus(ops[k], 1'b0);
      got = actual_vec();
      vectors++;
      if (got !== 14'd0) begin
        miscompares++;
        $display("[TB] FAIL nop_%b got=%b want=%b", ops[k], got, 14'd0);
      end
    end
  endtask

  task automatic test_reset_release();
    logic [13:0] got;
    @(negedge clock);
    applyStimulus(7'b1101111, 1'b1);
    got = actual_vec();
    vectors++;
    if (got !== 14'd0) begin
      miscompares++;
      $display("[TB] FAIL jal_under_reset got=%b want=%b", got, 14'd0);
    end
    applyStimulus(7'b1101111, 1'b0);
    vectors++;
    if ({next_PC_sel, operand_A_sel, regWrite} !== 5'b10_10_1) begin
      miscompares++;
      $display("[TB] FAIL jal_after_release got=%b want=%b",
               {next_PC_sel, operand_A_sel, regWrite}, 5'b10_10_1);
    end
  endtask

  task automatic test_exhaustive_sweep();
    logic [6:0]  opc;
    logic [13:0] got;
    logic        jump_like;
    for (int k = 0; k < 128; k++) begin
      opc = 7'(k);
      applyStimulus(opc, 1'b0);
      got = actual_vec();
      jump_like = (opc == 7'b1100011) || (opc == 7'b1101111) || (opc == 7'b1100111);
      vectors++;
      if (got !== model(opc, 1'b0)) begin
        miscompares++;
        $display("[TB] FAIL sweep_%b got=%b want=%b", opc, got, model(opc, 1'b0));
      end
      vectors++;
      if ((memRead & memWrite) !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL rw_exclusive_%b got=%b want=0", opc, memRead & memWrite);
      end
      vectors++;
      if ((next_PC_sel != 2'b00) !== jump_like) begin
        miscompares++;
        $display("[TB] FAIL npc_only_jumps_%b got=%b want_nonzero=%b", opc, next_PC_sel, jump_like);
      end
    end
  endtask

  task automatic test_random();
    logic [6:0]  opc;
    logic        rst;
    logic [13:0] got;
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(1, 0) == 1) opc = defined_ops[$urandom_range(8, 0)];
      else opc = 7'($urandom);
      rst = ($urandom_range(7, 0) == 0);
      applyStimulus(opc, rst);
      got = actual_vec();
      vectors++;
      if (got !== model(opc, rst)) begin
        miscompares++;
        $display("[TB] FAIL random_%b_rst%b got=%b want=%b", opc, rst, got, model(opc, rst));
      end
    end
  endtask

`ifdef CU_PERF_COUNTERS_EN
  // Counter model: index 0 is cycles, 1..8 are r, i, load, store, branch, jump, upper, nop.
  logic [31:0] exp_cnt [9];

  function automatic int class_idx(input logic [6:0] opc);
    if (opc == 7'b0110011) return 1;
    if (opc == 7'b0010011) return 2;
    if (opc == 7'b0000011) return 3;
    if (opc == 7'b0100011) return 4;
    if (opc == 7'b1100011) return 5;
    if (opc == 7'b1101111 || opc == 7'b1100111) return 6;
    if (opc == 7'b0110111 || opc == 7'b0010111) return 7;
    return 8;
  endfunction

  function automatic logic [31:0] dut_cnt(input int idx);
    case (idx)
      0:       return dut.u_perf.cycles;
      1:       return dut.u_perf.r_cnt;
      2:       return dut.u_perf.i_cnt;
      3:       return dut.u_perf.load_cnt;
      4:       return dut.u_perf.store_cnt;
      5:       return dut.u_perf.branch_cnt;
      6:       return dut.u_perf.jump_cnt;
      7:       return dut.u_perf.upper_cnt;
      default: return dut.u_perf.nop_cnt;
    endcase
  endfunction

  task automatic perf_cycle(input logic [6:0] opc, input logic rst, input logic rep);
    @(negedge clock);
    opcode = opc;
    reset  = rst;
    report = rep;
    @(posedge clock);
    if (rst) begin
      for (int j = 0; j < 9; j++) exp_cnt[j] = '0;
    end else begin
      exp_cnt[0] = exp_cnt[0] + 32'd1;
      exp_cnt[class_idx(opc)] = exp_cnt[class_idx(opc)] + 32'd1;
    end
    #1;
  endtask

  task automatic test_perf_counts();
    logic [6:0] seq [10];
    seq = '{7'b0110011, 7'b0110011, 7'b0110011, 7'b0000011, 7'b0000011,
            7'b1100011, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};
    perf_cycle(7'b0000000, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) perf_cycle(seq[k], 1'b0, 1'b0);
    for (int j = 0; j < 9; j++) begin
      vectors++;
      if (dut_cnt(j) !== exp_cnt[j]) begin
        miscompares++;
        $display("[TB] FAIL perf_count_%0d got=%0d want=%0d", j, dut_cnt(j), exp_cnt[j]);
      end
    end
    perf_cycle(7'b0010011, 1'b0, 1'b1);
    for (int k = 0; k < 60; k++) perf_cycle(7'($urandom), 1'b0, 1'b0);
    for (int j = 0; j < 9; j++) begin
      vectors++;
      if (dut_cnt(j) !== exp_cnt[j]) begin
        miscompares++;
        $display("[TB] FAIL perf_random_%0d got=%0d want=%0d", j, dut_cnt(j), exp_cnt[j]);
      end
    end
  endtask

  task automatic test_perf_reset();
    for (int k = 0; k < 15; k++) perf_cycle(defined_ops[$urandom_range(8, 0)], 1'b0, 1'b0);
    perf_cycle(7'b0110011, 1'b1, 1'b1);
    for (int j = 0; j < 9; j++) begin
      vectors++;
      if (dut_cnt(j) !== 32'd0) begin
        miscompares++;
        $display("[TB] FAIL perf_midrun_reset_%0d got=%0d want=0", j, dut_cnt(j));
      end
    end
    perf_cycle(7'b0100011, 1'b0, 1'b0);
    vectors++;
    if (dut_cnt(4) !== exp_cnt[4]) begin
      miscompares++;
      $display("[TB] FAIL perf_after_reset_store got=%0d want=%0d", dut_cnt(4), exp_cnt[4]);
    end
    report = 1'b0;
  endtask
`endif

  initial begin
    clock       = 1'b0;
    reset       = 1'b1;
    opcode      = 7'd0;
    report      = 1'b0;
    vectors     = 0;
    miscompares = 0;
    build_table();
    test_reset();
    test_defined_opcodes();
    test_undefined_opcodes();
    test_reset_release();
    test_exhaustive_sweep();
    test_random();
`ifdef CU_PERF_COUNTERS_EN
    test_perf_counts();
    test_perf_reset();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/riscv_control_unit.md
Name: riscv_control_unit

Overview:
Main decoder of the 5-stage RV32I pipeline. Sits in EX and takes the 7-bit opcode from the ID/EX register. Combinationally produces ALU-operation class, operand selects, immediate-format select, next-PC select and memory/register-write enables. Counters for instruction classes are optional.

Parameters:
CORE, 0, core index; used only in report messages.

Ports:
clock  input  1  system clock; used only by the optional counters
reset  input  1  synchronous, active-high reset
opcode  input  7  instruction bits [6:0]
report  input  1  performance-report request
branch_op  output  1  conditional branch instruction
memRead  output  1  load; also selects the memory path in writeback
ALUOp  output  3  ALU operation class
memWrite  output  1  store
next_PC_sel  output  2  00 PC+4, 01 branch, 10 JAL, 11 JALR
operand_A_sel  output  2  00 rs1, 01 PC, 10 PC+4, 11 zero
operand_B_sel  output  1  0 rs2, 1 extended immediate
extend_sel  output  2  00 I-imm, 01 U-imm, 10 S-imm
regWrite  output  1  writes rd

Behaviour:
- All outputs are a purely combinational function of opcode and reset; zero cycles of latency.
- Any output not listed for an opcode is 0.
- R-type 0110011: ALUOp 000, regWrite 1.
- I-ALU 0010011: ALUOp 001, operand_B_sel 1, extend_sel 00, regWrite 1.
- Load 0000011: ALUOp 100, memRead 1, operand_B_sel 1, extend_sel 00, regWrite 1.
- Store 0100011: ALUOp 101, memWrite 1, operand_B_sel 1, extend_sel 10, regWrite 0.
- Branch 1100011: ALUOp 010, branch_op 1, next_PC_sel 01, regWrite 0.
- JAL 1101111: ALUOp 011, next_PC_sel 10, operand_A_sel 10, regWrite 1.
- JALR 1100111: ALUOp 011, next_PC_sel 11, operand_A_sel 10, operand_B_sel 1, extend_sel 00, regWrite 1.
- LUI 0110111: ALUOp 110, operand_A_sel 11, operand_B_sel 1, extend_sel 01, regWrite 1.
- AUIPC 0010111: ALUOp 111, operand_A_sel 01, operand_B_sel 1, extend_sel 01, regWrite 1.
- Any other opcode, including 0000000 (bubble) and SYSTEM/FENCE: all outputs 0, i.e. a NOP with no writes and next_PC_sel 00.
- reset high: all outputs 0, regardless of opcode. In the same cycle that reset deasserts, outputs follow opcode.
- The outputs contain no state, so they never hold an X derived from history.
- memRead and memWrite are never both 1.
- next_PC_sel is nonzero only for branch/JAL/JALR.

Optional Feature:
Macro CU_PERF_COUNTERS_EN.
- Defined: 32-bit counters, all cleared to 0 on reset:
  - cycles
  - r_cnt, i_cnt, load_cnt, store_cnt, branch_cnt, jump_cnt (JAL+JALR), upper_cnt (LUI+AUIPC), nop_cnt (undefined opcodes)
- Each non-reset posedge: cycles increments; exactly one class counter increments according to the current opcode.
- Counters wrap modulo 2^32.
- On any posedge with report high and reset low, print once: CORE, then every counter value, as sampled before that edge's increment.
- Not defined: no counters; clock and report are unused; no messages; decode behaviour identical.

Decomposition:
- Shared package rv_ctrl_pkg holds:
  - opcode constants (OPC_RTYPE, OPC_ITYPE, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC)
  - ALUOp codes
  - next-PC, operand-A and extend-select encodings
- The same package is used by execution_unit and decode_unit.
- One sub-module is natural: riscv_control_perf_counters, instantiated only under CU_PERF_COUNTERS_EN. The decoder itself is a single case statement.

Test Plan:
- Sweep all nine defined opcodes with reset low -> each output vector exactly as listed (e.g. 0100011 -> ALUOp 101, memWrite 1, operand_B_sel 1, extend_sel 10, regWrite 0).
- Opcodes 0000000, 1110011, 0001111 and 1111111 -> all outputs 0.
- reset high with opcode 1101111 -> all outputs 0; deassert reset -> next_PC_sel 10, operand_A_sel 10, regWrite 1 with no cycle delay.
- Exhaustive 128-opcode sweep -> memRead&memWrite never 1; next_PC_sel nonzero only for 1100011/1101111/1100111.
- CU_PERF_COUNTERS_EN: reset, then 3 R-type, 2 load, 1 branch, 4 opcode-0 cycles, then report high -> printout cycles=10, r=3, load=2, branch=1, nop=4, all others 0.
- CU_PERF_COUNTERS_EN: assert reset mid-run -> all counters 0 next edge; no message while reset is high, even with report high.
